cdr_loop_filter: RTL and testbench
==================================

CDR_LOOP_FILTER -- requirements
Module: cdr_loop_filter

Interface
REQ-001 SHALL have parameter VOTE_LEN, default 8, giving the number of cycles per vote window (power of two, 2..64).
REQ-002 SHALL have parameter INT_W, default 10, giving the signed width of the integral (frequency) register.
REQ-003 SHALL have parameter PI_CODE_W, default 7, giving the width of the phase-interpolator code.
REQ-004 SHALL have parameter FRAC_W, default 5, giving the fractional bits below the PI code in the phase accumulator.
REQ-005 SHALL have parameter KP, default 4, giving the proportional step in phase-accumulator LSBs.
REQ-006 SHALL have parameter KI_SHIFT, default 4, giving the arithmetic right shift applied to the integral before phase addition.
REQ-007 SHALL have parameter LOCK_CNT, default 15, giving the consecutive non-trending windows needed for lock.
REQ-008 SHALL have port clk, input, 1 bit: the single recovered-clock domain; all state updates on its rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-010 SHALL have port enable, input, 1 bit: when high, samples are accepted; when low, all state is frozen.
REQ-011 SHALL have port Up, input, 1 bit: early/late indication from the bang-bang phase detector, meaning advance phase.
REQ-012 SHALL have port Dn, input, 1 bit: early/late indication from the bang-bang phase detector, meaning retard phase.
REQ-013 SHALL have port pi_code, output, PI_CODE_W bits, equal to phase accumulator bits [PI_CODE_W+FRAC_W-1:FRAC_W].
REQ-014 SHALL have port code_valid, output, 1 bit: a one-cycle pulse indicating that pi_code changed.
REQ-015 SHALL have port freq_int, output, INT_W bits signed: the integral register, provided for observation.
REQ-016 SHALL have port lock, output, 1 bit: the lock indicator.

Function
REQ-017 SHALL form a per-cycle vote with enable high: Up&!Dn = +1; Dn&!Up = -1; Up&Dn or neither = 0.
REQ-018 SHALL accumulate votes in signed vote_sum, clog2(VOTE_LEN)+2 bits wide, and count cycles with win_cnt, 0..VOTE_LEN-1, wrapping.
REQ-019 SHALL, at the edge where win_cnt==VOTE_LEN-1 and enable=1, compute total = vote_sum + current vote; decision = sign(total) in {+1, 0, -1}; and clear vote_sum to 0.
REQ-020 SHALL, on a nonzero decision, update phase (PI_CODE_W+FRAC_W bits, unsigned) as phase += decision*KP + (freq_int_old >>> KI_SHIFT), using the pre-update integral, and wrap modulo 2^(PI_CODE_W+FRAC_W).
REQ-021 SHALL, on a nonzero decision, set freq_int += decision, saturating at +2^(INT_W-1)-1 and -2^(INT_W-1) with no wrap.
REQ-022 SHALL leave phase and freq_int unchanged and not pulse code_valid when decision = 0.
REQ-023 SHALL register pi_code, updating it on the window-end edge.
REQ-024 SHALL assert code_valid for exactly the one cycle after that edge, and only if pi_code changed value.
REQ-025 SHALL implement the lock FSM with states HUNT and LOCKED and a saturating counter lk_cnt.
REQ-026 SHALL, at each window end, increment lk_cnt when decision is 0 or opposite in sign to the previous nonzero decision, and clear lk_cnt to 0 when decision has the same sign as the previous nonzero decision.
REQ-027 SHALL transition HUNT->LOCKED when lk_cnt reaches LOCK_CNT, and LOCKED->HUNT when 3 consecutive windows have the same nonzero sign; lock=1 only in LOCKED.
REQ-028 SHALL freeze every register when enable=0; a window spans enabled cycles only.
REQ-029 SHALL, when enable falls mid-window and later resumes, continue the partial vote_sum and win_cnt.

Reset
REQ-030 SHALL, on a clk edge with rst_n=0, set vote_sum=0, win_cnt=0, phase=0, pi_code=0, freq_int=0, code_valid=0, lock=0, state=HUNT, lk_cnt=0, and previous decision=0, regardless of enable.
REQ-031 SHALL, on reset asserted mid-window, discard the partial window; the first post-reset window starts at win_cnt=0.

Verification
REQ-032 SHALL cover: Up=1, Dn=0 for 64 enabled cycles after reset -> freq_int=8, phase=32, pi_code=1 with one code_valid pulse, and all earlier windows produce no pulse.
REQ-033 SHALL cover: Dn=1, Up=0 for 8 cycles after reset -> phase=4092, pi_code=127 (wrap), freq_int=-1, and code_valid pulses once.
REQ-034 SHALL cover: 4 cycles Up then 4 cycles Dn, or Up=Dn=1 for 8 cycles -> no change to pi_code or freq_int and no code_valid.
REQ-035 SHALL cover: windows alternating all-Up/all-Dn for 16 windows -> lock=1 after window 16; then 3 all-Up windows -> lock=0.
REQ-036 SHALL cover: continuous Up for 600 windows -> freq_int saturates at 511 and never wraps negative.
REQ-037 SHALL cover: enable=0 for 5 cycles mid-window with Up=1 -> the window closes after 8 enabled cycles; rst_n=0 at win_cnt=5 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/cdr_loop_filter.sv
// cdr_loop_filter: second-order loop filter for a bang-bang clock/data recovery loop.
// Up/Dn votes are integrated over a fixed window. A signed decision at each window end
// steps a phase accumulator (proportional KP plus the scaled integral) and a saturating
// frequency integral. The upper phase bits drive the phase interpolator. A small FSM
// reports lock once windows stop trending in one direction.
module cdr_loop_filter #(
    parameter int VOTE_LEN  = 8,
    parameter int INT_W     = 10,
    parameter int PI_CODE_W = 7,
    parameter int FRAC_W    = 5,
    parameter int KP        = 4,
    parameter int KI_SHIFT  = 4,
    parameter int LOCK_CNT  = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    Up,
    input  logic                    Dn,
    output logic [PI_CODE_W-1:0]    pi_code,
    output logic                    code_valid,
    output logic signed [INT_W-1:0] freq_int,
    output logic                    lock
);
    localparam int CNT_W = $clog2(VOTE_LEN);
    localparam int VS_W  = $clog2(VOTE_LEN) + 2;
    localparam int PH_W  = PI_CODE_W + FRAC_W;
    localparam int LK_W  = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]        WIN_LAST = CNT_W'(VOTE_LEN - 1);
    localparam logic [LK_W-1:0]         LK_MAX   = LK_W'(LOCK_CNT);
    localparam logic signed [INT_W-1:0] FREQ_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] FREQ_MIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [PH_W-1:0]         KP_POS   = PH_W'(KP);
    localparam logic [PH_W-1:0]         KP_NEG   = PH_W'(-KP);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Single-cycle vote: +1 advance, -1 retard, 0 when both or neither are set.
    function automatic logic signed [1:0] vote_of(input logic up, input logic dn);
        logic signed [1:0] v;
        case ({up, dn})
            2'b10:   v = 2'sb01;
            2'b01:   v = 2'sb11;
            default: v = 2'sb00;
        endcase
        return v;
    endfunction

    // Sign of the window total as a signed {-1, 0, +1}.
    function automatic logic signed [1:0] sign_of(input logic signed [VS_W-1:0] t);
        logic signed [1:0] s;
        if (t == {VS_W{1'b0}}) begin
            s = 2'sb00;
        end else if (t[VS_W-1]) begin
            s = 2'sb11;
        end else begin
            s = 2'sb01;
        end
        return s;
    endfunction

    logic signed [VS_W-1:0]  vote_sum_r;
    logic [CNT_W-1:0]        win_cnt_r;
    logic [PH_W-1:0]         phase_r;
    logic [PI_CODE_W-1:0]    pi_code_r;
    logic                    code_valid_r;
    logic signed [INT_W-1:0] freq_int_r;
    logic                    lock_r;
    lock_state_t             state_r;
    logic [LK_W-1:0]         lk_cnt_r;
    logic signed [1:0]       prev_dec_r;
    logic [1:0]              run_r;

    logic signed [1:0]       vote_s;
    logic                    win_end_s;
    logic signed [VS_W-1:0]  total_s;
    logic signed [1:0]       dec_s;
    logic signed [INT_W-1:0] freq_shift_s;
    logic [PH_W-1:0]         step_s;
    logic [PH_W-1:0]         phase_nxt_s;
    logic [PI_CODE_W-1:0]    pi_nxt_s;
    logic                    changed_s;
    logic signed [INT_W-1:0] freq_nxt_s;
    lock_state_t             state_nxt_s;
    logic [LK_W-1:0]         lk_nxt_s;
    logic signed [1:0]       prev_nxt_s;
    logic [1:0]              run_nxt_s;
    logic [LK_W-1:0]         lk_inc_s;

    // Window decision, next phase step and saturating integral update.
    always_comb begin
        vote_s    = vote_of(Up, Dn);
        win_end_s = enable && (win_cnt_r == WIN_LAST);
        total_s   = vote_sum_r + VS_W'(vote_s);
        if (win_end_s) begin
            dec_s = sign_of(total_s);
        end else begin
            dec_s = 2'sb00;
        end
        // Integral contribution uses the value before this window's update.
        freq_shift_s = freq_int_r >>> KI_SHIFT;
        if (dec_s[1]) begin
            step_s = KP_NEG + PH_W'(freq_shift_s);
        end else begin
            step_s = KP_POS + PH_W'(freq_shift_s);
        end
        phase_nxt_s = phase_r + step_s;
        pi_nxt_s    = phase_nxt_s[PH_W-1:FRAC_W];
        changed_s   = (dec_s != 2'sb00) && (pi_nxt_s != pi_code_r);
        if ((dec_s == 2'sb01) && (freq_int_r != FREQ_MAX)) begin
            freq_nxt_s = freq_int_r + INT_W'(1);
        end else if ((dec_s == 2'sb11) && (freq_int_r != FREQ_MIN)) begin
            freq_nxt_s = freq_int_r - INT_W'(1);
        end else begin
            freq_nxt_s = freq_int_r;
        end
    end

    // Vote window, phase accumulator, integral and code outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vote_sum_r   <= {VS_W{1'b0}};
            win_cnt_r    <= {CNT_W{1'b0}};
            phase_r      <= {PH_W{1'b0}};
            pi_code_r    <= {PI_CODE_W{1'b0}};
            freq_int_r   <= {INT_W{1'b0}};
            code_valid_r <= 1'b0;
        end else begin
            // The pulse always self-clears so it lasts exactly one cycle.
            code_valid_r <= changed_s;
            if (enable) begin
                if (win_end_s) begin
                    vote_sum_r <= {VS_W{1'b0}};
                    win_cnt_r  <= {CNT_W{1'b0}};
                end else begin
                    vote_sum_r <= total_s;
                    win_cnt_r  <= win_cnt_r + CNT_W'(1);
                end
                if (dec_s != 2'sb00) begin
                    phase_r    <= phase_nxt_s;
                    pi_code_r  <= pi_nxt_s;
                    freq_int_r <= freq_nxt_s;
                end
            end
        end
    end

    // Lock FSM next state: lk_cnt counts non-trending windows, run_r counts same-sign streaks.
    always_comb begin
        state_nxt_s = state_r;
        lk_nxt_s    = lk_cnt_r;
        prev_nxt_s  = prev_dec_r;
        run_nxt_s   = run_r;
        lk_inc_s    = (lk_cnt_r == LK_MAX) ? LK_MAX : (lk_cnt_r + LK_W'(1));
        if (win_end_s) begin
            if (dec_s == 2'sb00) begin
                lk_nxt_s  = lk_inc_s;
                run_nxt_s = 2'd0;
            end else if (dec_s == prev_dec_r) begin
                lk_nxt_s  = {LK_W{1'b0}};
                run_nxt_s = (run_r == 2'd3) ? 2'd3 : (run_r + 2'd1);
            end else begin
                // With no earlier nonzero decision there is nothing to oppose.
                if (prev_dec_r != 2'sb00) begin
                    lk_nxt_s = lk_inc_s;
                end else begin
                    lk_nxt_s = lk_cnt_r;
                end
                run_nxt_s  = 2'd1;
                prev_nxt_s = dec_s;
            end
            case (state_r)
                HUNT: begin
                    if (lk_nxt_s == LK_MAX) begin
                        state_nxt_s = LOCKED;
                    end else begin
                        state_nxt_s = HUNT;
                    end
                end
                LOCKED: begin
                    if (run_nxt_s == 2'd3) begin
                        state_nxt_s = HUNT;
                    end else begin
                        state_nxt_s = LOCKED;
                    end
                end
                default: state_nxt_s = HUNT;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Lock FSM state register and registered lock flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= HUNT;
            lk_cnt_r   <= {LK_W{1'b0}};
            prev_dec_r <= 2'sb00;
            run_r      <= 2'd0;
            lock_r     <= 1'b0;
        end else if (enable) begin
            state_r    <= state_nxt_s;
            lk_cnt_r   <= lk_nxt_s;
            prev_dec_r <= prev_nxt_s;
            run_r      <= run_nxt_s;
            lock_r     <= (state_nxt_s == LOCKED);
        end
    end

    assign pi_code    = pi_code_r;
    assign code_valid = code_valid_r;
    assign freq_int   = freq_int_r;
    assign lock       = lock_r;

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Directed bench for cdr_loop_filter with default parameters (8-cycle windows,
// 12-bit phase, 7-bit PI code, 10-bit integral, KP=4, KI_SHIFT=4, LOCK_CNT=15).
module tb_cdr_loop_filter;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              Up;
    logic              Dn;
    logic [6:0]        pi_code;
    logic              code_valid;
    logic signed [9:0] freq_int;
    logic              lock;

    int n_checks = 0;
    int n_fail   = 0;

    cdr_loop_filter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .Up         (Up),
        .Dn         (Dn),
        .pi_code    (pi_code),
        .code_valid (code_valid),
        .freq_int   (freq_int),
        .lock       (lock)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n cycles with constant inputs and count code_valid pulses seen.
    task automatic run(input int n, input logic en, input logic up, input logic dn, output int pulses);
        pulses = 0;
        enable = en;
        Up     = up;
        Dn     = dn;
        for (int i = 0; i < n; i++) begin
            tick();
            if (code_valid === 1'b1) pulses++;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        Up     = 1'b0;
        Dn     = 1'b0;
        tick();
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        Up     = 1'b1;
        Dn     = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({pi_code, code_valid, freq_int, lock} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state: got pi=%0d cv=%0b freq=%0d lock=%0b required all 0",
                     pi_code, code_valid, freq_int, lock);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_up_ramp();
        int p1, p2, p3;
        do_reset();
        run(8, 1'b1, 1'b1, 1'b0, p1);
        n_checks++;
        if (freq_int !== 10'sd1 || pi_code !== 7'd0) begin
            n_fail++;
            $display("FAIL up_first_window: got freq=%0d pi=%0d required 1 0", freq_int, pi_code);
        end
        run(56, 1'b1, 1'b1, 1'b0, p2);
        n_checks++;
        if (freq_int !== 10'sd8) begin
            n_fail++;
            $display("FAIL up_freq: got %0d required 8", freq_int);
        end
        n_checks++;
        if (pi_code !== 7'd1) begin
            n_fail++;
            $display("FAIL up_pi_code: got %0d required 1", pi_code);
        end
        n_checks++;
        if (code_valid !== 1'b1 || (p1 + p2) != 1) begin
            n_fail++;
            $display("FAIL up_pulse: got cv=%0b pulses=%0d required cv=1 pulses=1", code_valid, p1 + p2);
        end
        run(1, 1'b0, 1'b1, 1'b0, p3);
        n_checks++;
        if (code_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL up_pulse_width: got cv=%0b required 0", code_valid);
        end
    endtask

    task automatic test_dn_wrap();
        int p;
        do_reset();
        run(8, 1'b1, 1'b0, 1'b1, p);
        n_checks++;
        if (pi_code !== 7'd127) begin
            n_fail++;
            $display("FAIL dn_wrap_pi: got %0d required 127", pi_code);
        end
        n_checks++;
        if (freq_int !== -10'sd1) begin
            n_fail++;
            $display("FAIL dn_freq: got %0d required -1", freq_int);
        end
        n_checks++;
        if (p != 1 || code_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL dn_pulse: got pulses=%0d cv=%0b required 1 1", p, code_valid);
        end
    endtask

    task automatic test_no_change();
        int p1, p2, p3;
        do_reset();
        run(4, 1'b1, 1'b1, 1'b0, p1);
        run(4, 1'b1, 1'b0, 1'b1, p2);
        run(8, 1'b1, 1'b1, 1'b1, p3);
        n_checks++;
        if (pi_code !== 7'd0 || freq_int !== 10'sd0) begin
            n_fail++;
            $display("FAIL balanced_hold: got pi=%0d freq=%0d required 0 0", pi_code, freq_int);
        end
        n_checks++;
        if ((p1 + p2 + p3) != 0) begin
            n_fail++;
            $display("FAIL balanced_pulse: got pulses=%0d required 0", p1 + p2 + p3);
        end
    endtask

    task automatic test_lock();
        int p;
        do_reset();
        for (int w = 1; w <= 16; w++) begin
            if (w % 2 == 1) run(8, 1'b1, 1'b1, 1'b0, p);
            else            run(8, 1'b1, 1'b0, 1'b1, p);
            if (w == 15) begin
                n_checks++;
                if (lock !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lock_early: got %0b after window 15 required 0", lock);
                end
            end
        end
        n_checks++;
        if (lock !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_acquire: got %0b after window 16 required 1", lock);
        end
        run(16, 1'b1, 1'b1, 1'b0, p);
        n_checks++;
        if (lock !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_hold: got %0b after 2 trending windows required 1", lock);
        end
        run(8, 1'b1, 1'b1, 1'b0, p);
        n_checks++;
        if (lock !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_lose: got %0b after 3 trending windows required 0", lock);
        end
    endtask

    task automatic test_saturate();
        int p;
        int neg;
        neg = 0;
        do_reset();
        for (int w = 1; w <= 600; w++) begin
            run(8, 1'b1, 1'b1, 1'b0, p);
            if (freq_int < 0) neg++;
            if (w == 511) begin
                n_checks++;
                if (freq_int !== 10'sd511) begin
                    n_fail++;
                    $display("FAIL sat_reach: got %0d at window 511 required 511", freq_int);
                end
            end
        end
        n_checks++;
        if (freq_int !== 10'sd511 || neg != 0) begin
            n_fail++;
            $display("FAIL sat_hold: got freq=%0d negatives=%0d required 511 0", freq_int, neg);
        end
    endtask

    task automatic test_enable_freeze();
        int p1, p2, p3, p4;
        do_reset();
        run(3, 1'b1, 1'b1, 1'b0, p1);
        run(5, 1'b0, 1'b1, 1'b0, p2);
        run(4, 1'b1, 1'b1, 1'b0, p3);
        n_checks++;
        if (freq_int !== 10'sd0) begin
            n_fail++;
            $display("FAIL freeze_early_close: got freq=%0d after 7 enabled cycles required 0", freq_int);
        end
        run(1, 1'b1, 1'b1, 1'b0, p4);
        n_checks++;
        if (freq_int !== 10'sd1 || pi_code !== 7'd0 || (p1 + p2 + p3 + p4) != 0) begin
            n_fail++;
            $display("FAIL freeze_close: got freq=%0d pi=%0d pulses=%0d required 1 0 0",
                     freq_int, pi_code, p1 + p2 + p3 + p4);
        end
    endtask

    task automatic test_reset_mid();
        int p;
        run(5, 1'b1, 1'b1, 1'b0, p);
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({pi_code, code_valid, freq_int, lock} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got pi=%0d cv=%0b freq=%0d lock=%0b required all 0",
                     pi_code, code_valid, freq_int, lock);
        end
        rst_n = 1'b1;
        run(7, 1'b1, 1'b0, 1'b1, p);
        n_checks++;
        if (freq_int !== 10'sd0) begin
            n_fail++;
            $display("FAIL reset_partial: got freq=%0d after 7 cycles required 0", freq_int);
        end
        run(1, 1'b1, 1'b0, 1'b1, p);
        n_checks++;
        if (freq_int !== -10'sd1 || pi_code !== 7'd127 || p != 1) begin
            n_fail++;
            $display("FAIL reset_first_window: got freq=%0d pi=%0d pulses=%0d required -1 127 1",
                     freq_int, pi_code, p);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        Up     = 1'b0;
        Dn     = 1'b0;
        test_reset();
        test_up_ramp();
        test_dn_wrap();
        test_no_change();
        test_lock();
        test_saturate();
        test_enable_freeze();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
